// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: gathers 5-byte frames (opcode + 4 args) from the UART
// receiver, decodes them and holds the capture configuration registers.
module sump_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TO_W           = 18
) (
  input  logic        system_clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        capture_busy,
  output logic [23:0] divider,
  output logic [15:0] read_count,
  output logic [15:0] delay_count,
  output logic [7:0]  trig_rise,
  output logic [7:0]  trig_fall,
  output logic        soft_reset,
  output logic        arm,
  output logic        id_req,
  output logic        meta_req,
  output logic        cmd_error,
  output logic        frame_busy
);

  localparam logic [7:0] OP_RESET = 8'h00;
  localparam logic [7:0] OP_ARM   = 8'h01;
  localparam logic [7:0] OP_META  = 8'h02;
  localparam logic [7:0] OP_ID    = 8'h04;
  localparam logic [7:0] OP_DIV   = 8'h80;
  localparam logic [7:0] OP_CNT   = 8'h81;
  localparam logic [7:0] OP_TRIG  = 8'hC1;

  // The frame is dropped on the edge where the idle counter would reach
  // TIMEOUT_CYCLES-1, so the compare value is one below that.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EXEC    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [2:0]      idx;
  logic [TO_W-1:0] to_cnt;

  logic [7:0]      opcode;
  logic [7:0]      arg1;
  logic [7:0]      arg2;
  logic [7:0]      arg3;
  logic [7:0]      arg4;

  logic            take_op;
  logic            take_arg;
  logic            exec;
  logic            timeout;

  logic            sr_nxt;
  logic            arm_nxt;
  logic            id_nxt;
  logic            meta_nxt;
  logic            err_nxt;
  logic            wr_div;
  logic            wr_cnt;
  logic            wr_trig;

  // A frame is in progress only while argument bytes are still expected.
  assign frame_busy = (state == COLLECT);

  // State register.
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: byte acceptance, frame completion and idle timeout.
  always_comb begin
    state_nxt = state;
    take_op   = 1'b0;
    take_arg  = 1'b0;
    exec      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          take_op   = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          take_arg = 1'b1;
          if (idx == 3'd4) begin
            state_nxt = EXEC;
          end
        end else if (to_cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      EXEC: begin
        exec = 1'b1;
        // A byte arriving during the execute cycle opens the next frame.
        if (rx_valid) begin
          take_op   = 1'b1;
          state_nxt = COLLECT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Opcode decode during the execute cycle; writes are refused while capturing.
  always_comb begin
    sr_nxt   = 1'b0;
    arm_nxt  = 1'b0;
    id_nxt   = 1'b0;
    meta_nxt = 1'b0;
    err_nxt  = timeout;
    wr_div   = 1'b0;
    wr_cnt   = 1'b0;
    wr_trig  = 1'b0;
    if (exec) begin
      case (opcode)
        OP_RESET: sr_nxt = 1'b1;
        OP_ARM: begin
          if (capture_busy) err_nxt = 1'b1;
          else              arm_nxt = 1'b1;
        end
        OP_META:  meta_nxt = 1'b1;
        OP_ID:    id_nxt   = 1'b1;
        OP_DIV: begin
          if (capture_busy) err_nxt = 1'b1;
          else              wr_div  = 1'b1;
        end
        OP_CNT: begin
          if (capture_busy) err_nxt = 1'b1;
          else              wr_cnt  = 1'b1;
        end
        OP_TRIG: begin
          if (capture_busy) err_nxt = 1'b1;
          else              wr_trig = 1'b1;
        end
        default:  err_nxt = 1'b1;
      endcase
    end
  end

  // Byte index and idle counter; any received byte restarts the idle count.
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      idx    <= 3'd0;
      to_cnt <= '0;
    end else begin
      if (take_op) begin
        idx <= 3'd1;
      end else if (take_arg) begin
        idx <= idx + 3'd1;
      end else if (state_nxt == IDLE) begin
        idx <= 3'd0;
      end

      if (state == COLLECT && !rx_valid && !timeout) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // Frame byte capture; contents only matter once a full frame is present.
  always_ff @(posedge system_clock) begin
    if (take_op) begin
      opcode <= rx_data;
    end
    if (take_arg) begin
      case (idx)
        3'd1:    arg1 <= rx_data;
        3'd2:    arg2 <= rx_data;
        3'd3:    arg3 <= rx_data;
        default: arg4 <= rx_data;
      endcase
    end
  end

  // Configuration registers; opcode 0x00 clears them like a reset.
  always_ff @(posedge system_clock) begin
    if (!reset_n || sr_nxt) begin
      divider     <= 24'd0;
      read_count  <= 16'd0;
      delay_count <= 16'd0;
      trig_rise   <= 8'd0;
      trig_fall   <= 8'd0;
    end else begin
      if (wr_div) begin
        divider <= {arg2, arg3, arg4};
      end
      if (wr_cnt) begin
        read_count  <= {arg1, arg2};
        delay_count <= {arg3, arg4};
      end
      if (wr_trig) begin
        trig_fall <= arg3;
        trig_rise <= arg4;
      end
    end
  end

  // Registered single-cycle control strobes.
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      soft_reset <= 1'b0;
      arm        <= 1'b0;
      id_req     <= 1'b0;
      meta_req   <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      soft_reset <= sr_nxt;
      arm        <= arm_nxt;
      id_req     <= id_nxt;
      meta_req   <= meta_nxt;
      cmd_error  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Bench for sump_cmd_decoder: frame-level reference model checked every cycle,
// plus literal expectations on configuration values and pulse counts.
module tb_sump_cmd_decoder;

  localparam int TO_CYC = 50;

  logic        system_clock = 1'b0;
  logic        reset_n      = 1'b0;
  logic [7:0]  rx_data      = 8'h00;
  logic        rx_valid     = 1'b0;
  logic        capture_busy = 1'b0;
  logic [23:0] divider;
  logic [15:0] read_count;
  logic [15:0] delay_count;
  logic [7:0]  trig_rise;
  logic [7:0]  trig_fall;
  logic        soft_reset;
  logic        arm;
  logic        id_req;
  logic        meta_req;
  logic        cmd_error;
  logic        frame_busy;

  sump_cmd_decoder #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(18)) dut (
    .system_clock(system_clock),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .capture_busy(capture_busy),
    .divider     (divider),
    .read_count  (read_count),
    .delay_count (delay_count),
    .trig_rise   (trig_rise),
    .trig_fall   (trig_fall),
    .soft_reset  (soft_reset),
    .arm         (arm),
    .id_req      (id_req),
    .meta_req    (meta_req),
    .cmd_error   (cmd_error),
    .frame_busy  (frame_busy)
  );

  always #5 system_clock = ~system_clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes since the last frame boundary, cycles since the
  // last byte, and a completed frame waiting for its execute cycle.
  logic [7:0]  q[$];
  int          idle = 0;
  bit          pend = 0;
  logic [7:0]  pf[5];
  logic [23:0] m_div  = '0;
  logic [15:0] m_rc   = '0;
  logic [15:0] m_dc   = '0;
  logic [7:0]  m_tr   = '0;
  logic [7:0]  m_tf   = '0;
  bit          m_sr = 0, m_arm = 0, m_id = 0, m_meta = 0, m_err = 0, m_fb = 0;
  bit          chk_on = 0;

  int n_sr = 0, n_arm = 0, n_id = 0, n_meta = 0, n_err = 0;

  task exec_frame(input bit busy);
    case (pf[0])
      8'h00: begin
        m_sr = 1; m_div = '0; m_rc = '0; m_dc = '0; m_tr = '0; m_tf = '0;
      end
      8'h01: if (busy) m_err = 1; else m_arm = 1;
      8'h02: m_meta = 1;
      8'h04: m_id = 1;
      8'h80: if (busy) m_err = 1; else m_div = {pf[2], pf[3], pf[4]};
      8'h81: if (busy) m_err = 1; else begin m_rc = {pf[1], pf[2]}; m_dc = {pf[3], pf[4]}; end
      8'hC1: if (busy) m_err = 1; else begin m_tf = pf[3]; m_tr = pf[4]; end
      default: m_err = 1;
    endcase
  endtask

  // Compare against the model, count pulses, then advance the model by the
  // inputs present in this cycle.
  always @(negedge system_clock) begin
    if (chk_on) begin
      chk("divider",     32'(divider),     32'(m_div));
      chk("read_count",  32'(read_count),  32'(m_rc));
      chk("delay_count", 32'(delay_count), 32'(m_dc));
      chk("trig_rise",   32'(trig_rise),   32'(m_tr));
      chk("trig_fall",   32'(trig_fall),   32'(m_tf));
      chk("soft_reset",  32'(soft_reset),  32'(m_sr));
      chk("arm",         32'(arm),         32'(m_arm));
      chk("id_req",      32'(id_req),      32'(m_id));
      chk("meta_req",    32'(meta_req),    32'(m_meta));
      chk("cmd_error",   32'(cmd_error),   32'(m_err));
      chk("frame_busy",  32'(frame_busy),  32'(m_fb));
    end
    n_sr   += int'(soft_reset);
    n_arm  += int'(arm);
    n_id   += int'(id_req);
    n_meta += int'(meta_req);
    n_err  += int'(cmd_error);

    m_sr = 0; m_arm = 0; m_id = 0; m_meta = 0; m_err = 0;
    if (!reset_n) begin
      q.delete();
      idle = 0; pend = 0;
      m_div = '0; m_rc = '0; m_dc = '0; m_tr = '0; m_tf = '0;
      chk_on = 1;
    end else begin
      if (pend) begin
        pend = 0;
        exec_frame(capture_busy);
      end
      if (rx_valid) begin
        q.push_back(rx_data);
        idle = 0;
        if (q.size() == 5) begin
          for (int i = 0; i < 5; i++) pf[i] = q[i];
          pend = 1;
          q.delete();
        end
      end else if (q.size() > 0) begin
        idle++;
        if (idle == TO_CYC - 1) begin
          q.delete();
          m_err = 1;
        end
      end
    end
    m_fb = (q.size() > 0);
  end

  task automatic tick();
    @(posedge system_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input int gap);
    logic [7:0] f[5];
    f[0] = b0; f[1] = b1; f[2] = b2; f[3] = b3; f[4] = b4;
    for (int i = 0; i < 5; i++) begin
      send_byte(f[i]);
      if (i < 4) repeat (gap) tick();
    end
  endtask

  int s_sr, s_arm, s_id, s_meta, s_err;
  int err_at;

  task automatic snap();
    s_sr = n_sr; s_arm = n_arm; s_id = n_id; s_meta = n_meta; s_err = n_err;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst divider",    32'(divider),    32'h0);
    chk("rst read_count", 32'(read_count), 32'h0);
    chk("rst trig_rise",  32'(trig_rise),  32'h0);
    chk("rst frame_busy", 32'(frame_busy), 32'h0);
    chk("rst cmd_error",  32'(cmd_error),  32'h0);

    // Divider write.
    snap();
    send_frame(8'h80, 8'h00, 8'h12, 8'h34, 8'h56, 2);
    repeat (3) tick();
    chk("div 123456", 32'(divider), 32'h123456);
    chk("div no pulse", 32'(n_sr + n_arm + n_id + n_meta + n_err - s_sr - s_arm - s_id - s_meta - s_err), 32'd0);

    // Counts, then trigger masks with the opcode landing in the execute cycle.
    send_frame(8'h81, 8'h00, 8'h10, 8'h00, 8'h08, 1);
    send_frame(8'hC1, 8'h00, 8'h00, 8'h0F, 8'hF0, 1);
    repeat (3) tick();
    chk("read_count 0010", 32'(read_count), 32'h0010);
    chk("delay_count 0008", 32'(delay_count), 32'h0008);
    chk("trig_fall 0F", 32'(trig_fall), 32'h0F);
    chk("trig_rise F0", 32'(trig_rise), 32'hF0);

    // ID and metadata queries.
    snap();
    send_frame(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    repeat (3) tick();
    send_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    repeat (3) tick();
    chk("id_req count", 32'(n_id - s_id), 32'd1);
    chk("meta_req count", 32'(n_meta - s_meta), 32'd1);
    chk("query no error", 32'(n_err - s_err), 32'd0);
    chk("query keeps div", 32'(divider), 32'h123456);

    // Writes and arm refused while capturing; soft reset still accepted.
    capture_busy = 1'b1;
    snap();
    send_frame(8'h80, 8'h00, 8'h00, 8'h00, 8'h01, 2);
    repeat (3) tick();
    chk("busy div kept", 32'(divider), 32'h123456);
    chk("busy div error", 32'(n_err - s_err), 32'd1);
    send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    repeat (3) tick();
    chk("busy arm refused", 32'(n_arm - s_arm), 32'd0);
    chk("busy arm error", 32'(n_err - s_err), 32'd2);
    send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    repeat (3) tick();
    chk("soft_reset count", 32'(n_sr - s_sr), 32'd1);
    chk("sr divider", 32'(divider), 32'h0);
    chk("sr read_count", 32'(read_count), 32'h0);
    chk("sr trig_rise", 32'(trig_rise), 32'h0);
    capture_busy = 1'b0;
    send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    repeat (3) tick();
    chk("arm count", 32'(n_arm - s_arm), 32'd1);

    // Idle timeout inside a partial frame.
    snap();
    send_byte(8'h81);
    tick();
    send_byte(8'hAB);
    err_at = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge system_clock);
      if (cmd_error && err_at < 0) err_at = i;
    end
    tick();
    chk("timeout cycle", 32'(err_at), 32'd50);
    chk("timeout errors", 32'(n_err - s_err), 32'd1);
    chk("timeout idle", 32'(frame_busy), 32'd0);
    send_frame(8'h81, 8'h00, 8'h02, 8'h00, 8'h01, 2);
    repeat (3) tick();
    chk("post-timeout rc", 32'(read_count), 32'h0002);
    chk("post-timeout dc", 32'(delay_count), 32'h0001);

    // Unknown opcode.
    snap();
    send_frame(8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 2);
    repeat (3) tick();
    chk("unknown error", 32'(n_err - s_err), 32'd1);
    chk("unknown other", 32'(n_sr + n_arm + n_id + n_meta - s_sr - s_arm - s_id - s_meta), 32'd0);
    chk("unknown keeps rc", 32'(read_count), 32'h0002);

    // Reset in the middle of a frame.
    send_frame(8'h80, 8'h00, 8'h00, 8'h00, 8'h07, 2);
    repeat (3) tick();
    chk("div 7", 32'(divider), 32'h7);
    send_byte(8'h80);
    tick();
    send_byte(8'h00);
    tick();
    send_byte(8'h11);
    reset_n = 1'b0;
    repeat (2) tick();
    chk("midrst divider", 32'(divider), 32'h0);
    chk("midrst read_count", 32'(read_count), 32'h0);
    chk("midrst frame_busy", 32'(frame_busy), 32'h0);
    reset_n = 1'b1;
    tick();
    send_frame(8'h81, 8'h00, 8'h03, 8'h00, 8'h04, 2);
    repeat (3) tick();
    chk("after rst rc", 32'(read_count), 32'h0003);
    chk("after rst dc", 32'(delay_count), 32'h0004);
    chk("after rst div", 32'(divider), 32'h0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
